uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port rx_in, input, 1 bit: serial line, already synchronised to clk, idle high.
REQ-004 SHALL have port prescale, input, 6 bits: oversampling ratio; legal values are 8, 16 and 32; other values give undefined behaviour.
REQ-005 SHALL have port par_en, input, 1 bit: a parity bit follows the data (present only with UART_RX_PARITY_EN).
REQ-006 SHALL have ports strt_glitch, par_err and stp_err, inputs, 1 bit each: registered checker results.
REQ-007 SHALL have ports edge_cnt (output, 6 bits) and bit_cnt (output, 4 bits): frame position counters.
REQ-008 SHALL have ports dat_samp_en, deser_en, strt_chk_en, par_chk_en and stp_chk_en, outputs, 1 bit each: enables to the datapath blocks.
REQ-009 SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a good frame.

Function
REQ-010 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-011 edge_cnt SHALL increment every cycle outside IDLE, and SHALL wrap to 0 after prescale-1.
REQ-012 bit_cnt SHALL increment when edge_cnt wraps, and SHALL clear on entry to IDLE or START.
REQ-013 Define mid = prescale>>1 and chk = mid+2; chk is the first cycle after the 3-sample majority is available.
REQ-014 IDLE: while rx_in=1, stay in IDLE with both counters at 0; when rx_in=0, go to START next cycle with edge_cnt=0.
REQ-015 dat_samp_en SHALL be 1 in every state except IDLE.
REQ-016 START: strt_chk_en SHALL pulse for exactly 1 cycle at edge_cnt=chk.
REQ-017 START: at edge_cnt=prescale-1, go to IDLE if strt_glitch=1, otherwise go to DATA.
REQ-018 DATA: deser_en SHALL pulse for 1 cycle at edge_cnt=chk for each of the 8 bits, LSB first, with bit_cnt = 1..8.
REQ-019 DATA: when bit_cnt=8 and edge_cnt=prescale-1, go to PARITY if parity is enabled, otherwise go to STOP.
REQ-020 PARITY: par_chk_en SHALL pulse at edge_cnt=chk; at edge_cnt=prescale-1, go to STOP.
REQ-021 STOP: stp_chk_en SHALL pulse at edge_cnt=chk.
REQ-022 STOP: at edge_cnt=prescale-1, data_valid SHALL be 1 for that one cycle only if stp_err=0 and (parity disabled or par_err=0).
REQ-023 STOP exit: go to START if rx_in=0 in that cycle (back-to-back frames), otherwise go to IDLE.
REQ-024 A failed frame (stp_err or par_err set) SHALL suppress data_valid and SHALL still return to IDLE/START per REQ-023.
REQ-025 Outputs SHALL be registered; no enable is ever asserted in IDLE.

Reset
REQ-026 When rst=0, state SHALL be IDLE, edge_cnt=0, bit_cnt=0 and all enables and data_valid SHALL be 0, asynchronously.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no data_valid; after rst=1, the next frame SHALL start only on a new falling rx_in.

Configuration
REQ-028 With UART_RX_PARITY_EN defined, port par_en, output par_chk_en, input par_err and the PARITY state SHALL exist; par_en=0 skips PARITY.
REQ-029 Without UART_RX_PARITY_EN, those ports and the PARITY state SHALL be absent, and DATA SHALL always go directly to STOP.

Verification
REQ-030 prescale=8, frame 0x55 with no parity and a good stop bit -> 8 deser_en pulses at edge_cnt=6, then data_valid=1 for 1 cycle, 80 cycles after the start edge.
REQ-031 prescale=16, rx_in low for 3 cycles then high, with strt_glitch=1 -> return to IDLE at edge_cnt=15; no deser_en and no data_valid.
REQ-032 UART_RX_PARITY_EN defined, par_en=1, prescale=32, par_err=1 -> PARITY visited, par_chk_en pulses at edge_cnt=18, data_valid stays 0.
REQ-033 prescale=8, stop bit sampled 0 (stp_err=1) -> no data_valid; FSM is in IDLE the cycle after edge_cnt=7 of STOP.
REQ-034 Two back-to-back frames 0xA3 and 0x3C at prescale=16 -> STOP goes directly to START, producing 2 data_valid pulses 160 cycles apart.
REQ-035 rst pulsed low at DATA bit_cnt=4 -> all outputs are 0 immediately, and the next frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer; parity stage present only with UART_RX_PARITY_EN
`timescale 1ns/1ps
module uart_rx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] prescale,
`ifdef UART_RX_PARITY_EN
    input  logic       par_en,
    input  logic       par_err,
    output logic       par_chk_en,
`endif
    input  logic       strt_glitch,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [5:0] edge_nx;
    logic [3:0] bit_nx;
    logic       valid_nx;
    logic       rx_q;
    logic [5:0] chk_cnt;
    logic [5:0] last_cnt;
    logic       last_edge;
    logic       par_on;
    logic       par_ok;

    assign chk_cnt   = {1'b0, prescale[5:1]} + 6'd2;
    assign last_cnt  = prescale - 6'd1;
    assign last_edge = (edge_cnt == last_cnt);

`ifdef UART_RX_PARITY_EN
    assign par_on = par_en;
    assign par_ok = !par_en || !par_err;
`else
    assign par_on = 1'b0;
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        edge_nx  = edge_cnt;
        bit_nx   = bit_cnt;
        valid_nx = 1'b0;
        if (state != IDLE) begin
            edge_nx = last_edge ? 6'd0 : edge_cnt + 6'd1;
            if (last_edge) begin
                bit_nx = bit_cnt + 4'd1;
            end
        end
        case (state)
            // Only a genuine high-to-low transition opens a frame, so a line
            // held low across reset is not mistaken for a start bit.
            IDLE: begin
                if (!rx_in && rx_q) begin
                    state_nx = START;
                end
            end
            START: begin
                if (last_edge) begin
                    state_nx = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_edge && bit_cnt == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = par_on ? PARITY : STOP;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (last_edge) begin
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (last_edge) begin
                    valid_nx = !stp_err && par_ok;
                    state_nx = rx_in ? IDLE : START;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == IDLE || (state_nx == START && state != START)) begin
            edge_nx = 6'd0;
            bit_nx  = 4'd0;
        end
    end

    // Enables are registered from next-state values so each pulse lines up
    // with the edge_cnt value it names; data_valid reports the decision taken
    // in the last STOP cycle, after the stop checker result has settled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            edge_cnt    <= 6'd0;
            bit_cnt     <= 4'd0;
            rx_q        <= 1'b0;
            dat_samp_en <= 1'b0;
            deser_en    <= 1'b0;
            strt_chk_en <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_chk_en  <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            edge_cnt    <= edge_nx;
            bit_cnt     <= bit_nx;
            rx_q        <= rx_in;
            dat_samp_en <= (state_nx != IDLE);
            deser_en    <= (state_nx == DATA)  && (edge_nx == chk_cnt);
            strt_chk_en <= (state_nx == START) && (edge_nx == chk_cnt);
            stp_chk_en  <= (state_nx == STOP)  && (edge_nx == chk_cnt);
            data_valid  <= valid_nx;
`ifdef UART_RX_PARITY_EN
            par_chk_en  <= (state_nx == PARITY) && (edge_nx == chk_cnt);
`endif
        end
    end

endmodule
